wm8731_cfg_seq: RTL and testbench



---
 rtl/wm8731_pkg.sv | 32 +++
 rtl/i2c_frame_tx.sv | 85 ++++++++
 rtl/wm8731_cfg_seq.sv | 111 +++++++++++
 tb/tb_wm8731_cfg_seq.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wm8731_pkg.sv
// Shared constants for the WM8731 power-up sequencer: device address, command ROM, state encoding.
// The ROM holds the register words that are sent in order after power-up.
package wm8731_pkg;

  localparam logic [7:0] DEV_ADDR_W = 8'h34;
  localparam int         ROM_DEPTH  = 11;
  localparam logic [5:0] PH_LAST    = 6'd58;

  localparam logic [15:0] CMD_ROM [ROM_DEPTH] = '{
    16'h1E00, 16'h0097, 16'h0297, 16'h0479, 16'h0679, 16'h0815,
    16'h0A00, 16'h0C00, 16'h0E42, 16'h1019, 16'h1201
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_FRAME,
    S_GAP,
    S_DONE,
    S_ERR
  } seq_state_e;

  // Indices past the end of the ROM read as zero.
  function automatic logic [15:0] cmd_word(input logic [3:0] idx);
    logic [15:0] w;
    w = '0;
    for (int k = 0; k < ROM_DEPTH; k++) begin
      if (idx == 4'(k)) w = CMD_ROM[k];
    end
    return w;
  endfunction

endpackage

// File: rtl/i2c_frame_tx.sv
// Sends one 24-bit I2C write frame: START, 3 bytes each followed by an ACK slot, STOP.
// Phase 0..58 is the phase currently on the pins; o_done pulses while phase 58 is shown.
module i2c_frame_tx
  import wm8731_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_go,
  input  logic [23:0] i_data,
  input  logic        i_sda,
  output logic        o_scl,
  output logic        o_sda_oe,
  output logic        o_done,
  output logic        o_nack
);

  logic        active_q;
  logic [5:0]  ph_q;
  logic [26:0] bits_q;
  logic        scl_q, sda_q, done_q, nack_q;

  logic [5:0]  ph_d;
  logic [4:0]  slot;
  logic        scl_d, sda_d;

  // Pin levels for the phase that follows the current one.
  always_comb begin
    ph_d  = ph_q + 6'd1;
    slot  = 5'((ph_d - 6'd2) >> 1);
    scl_d = 1'b1;
    sda_d = 1'b0;
    if (ph_d >= 6'd2 && ph_d <= 6'd55) begin
      scl_d = ph_d[0];
      sda_d = ~bits_q[5'd26 - slot];
    end else if (ph_d == 6'd1 || ph_d == 6'd57) begin
      sda_d = 1'b1;
    end else if (ph_d == 6'd56) begin
      scl_d = 1'b0;
      sda_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      active_q <= 1'b0;
      ph_q     <= '0;
      bits_q   <= '0;
      scl_q    <= 1'b1;
      sda_q    <= 1'b0;
      done_q   <= 1'b0;
      nack_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!active_q) begin
        if (i_go) begin
          active_q <= 1'b1;
          ph_q     <= '0;
          scl_q    <= 1'b1;
          sda_q    <= 1'b0;
          nack_q   <= 1'b0;
          // ACK slots carry a 1 so the line is released for the slave.
          bits_q   <= {i_data[23:16], 1'b1, i_data[15:8], 1'b1, i_data[7:0], 1'b1};
        end
      end else begin
        if ((ph_q == 6'd19 || ph_q == 6'd37 || ph_q == 6'd55) && i_sda) nack_q <= 1'b1;
        if (ph_q == PH_LAST - 6'd1) done_q <= 1'b1;
        if (ph_q == PH_LAST) begin
          active_q <= 1'b0;
          scl_q    <= 1'b1;
          sda_q    <= 1'b0;
        end else begin
          ph_q  <= ph_d;
          scl_q <= scl_d;
          sda_q <= sda_d;
        end
      end
    end
  end

  assign o_scl    = scl_q;
  assign o_sda_oe = sda_q;
  assign o_done   = done_q;
  assign o_nack   = nack_q;

endmodule

// File: rtl/wm8731_cfg_seq.sv
// WM8731 power-up configuration sequencer: walks the command ROM, one I2C frame per entry,
// retrying NACKed frames and reporting busy/done/error.
module wm8731_cfg_seq
  import wm8731_pkg::*;
#(
  parameter int NUM_CMDS   = ROM_DEPTH,
  parameter int GAP_CYCLES = 4,
  parameter int RETRY_MAX  = 3,
  parameter bit AUTO_START = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_sda,
  output logic       o_scl,
  output logic       o_sda_oe,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err,
  output logic [3:0] o_cmd_idx
);

  seq_state_e state_q;
  logic [3:0] idx_q, retry_q;
  logic [7:0] gap_q;
  logic       busy_q, done_q, err_q, auto_q;

  logic       restart, gap_last, go;
  logic [3:0] go_idx;
  logic       fr_done, fr_nack;

  assign restart  = (state_q == S_IDLE && (i_start || auto_q)) ||
                    ((state_q == S_DONE || state_q == S_ERR) && i_start);
  assign gap_last = (state_q == S_GAP) && (gap_q == 8'(GAP_CYCLES - 1));
  assign go       = restart || gap_last;
  // A restart sends entry 0 even though idx_q still shows the previous run.
  assign go_idx   = restart ? 4'd0 : idx_q;

  i2c_frame_tx u_tx (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_go     (go),
    .i_data   ({DEV_ADDR_W, cmd_word(go_idx)}),
    .i_sda    (i_sda),
    .o_scl    (o_scl),
    .o_sda_oe (o_sda_oe),
    .o_done   (fr_done),
    .o_nack   (fr_nack)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      retry_q <= '0;
      gap_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      auto_q  <= AUTO_START;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (restart) begin
            state_q <= S_FRAME;
            idx_q   <= '0;
            retry_q <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            auto_q  <= 1'b0;
          end
        end
        S_FRAME: begin
          if (fr_done) begin
            gap_q <= '0;
            if (!fr_nack) begin
              retry_q <= '0;
              if (idx_q == 4'(NUM_CMDS - 1)) begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                idx_q   <= idx_q + 4'd1;
                state_q <= S_GAP;
              end
            end else if (retry_q < 4'(RETRY_MAX)) begin
              retry_q <= retry_q + 4'd1;
              state_q <= S_GAP;
            end else begin
              state_q <= S_ERR;
              busy_q  <= 1'b0;
              err_q   <= 1'b1;
            end
          end
        end
        S_GAP: begin
          if (gap_last) state_q <= S_FRAME;
          else          gap_q   <= gap_q + 8'd1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_err     = err_q;
  assign o_cmd_idx = idx_q;

endmodule

// File: tb/tb_wm8731_cfg_seq.sv
// Bench for wm8731_cfg_seq: an I2C slave decoder rebuilds each frame from the bus and a
// scoreboard compares it with the frames queued by the stimulus; bus rules are checked too.
module tb_wm8731_cfg_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       i_sda;
  logic       scl, sda_oe, busy, done, err;
  logic [3:0] cmd_idx;

  always #5 clk = ~clk;

  wm8731_cfg_seq dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_start  (start),
    .i_sda    (i_sda),
    .o_scl    (scl),
    .o_sda_oe (sda_oe),
    .o_busy   (busy),
    .o_done   (done),
    .o_err    (err),
    .o_cmd_idx(cmd_idx)
  );

  localparam logic [15:0] ROM_TB [11] = '{
    16'h1E00, 16'h0097, 16'h0297, 16'h0479, 16'h0679, 16'h0815,
    16'h0A00, 16'h0C00, 16'h0E42, 16'h1019, 16'h1201
  };

  typedef struct {
    logic [23:0] data;
    int          period;
  } exp_t;
  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic rst_d = 1'b1;

  // Slave / monitor state
  logic pull = 1'b0;
  int   nack_mode = 0;
  bit   nacked_once = 0;
  int   frames = 0, starts = 0, scl_toggles = 0;
  int   stop_cyc = 0;

  assign i_sda = ~sda_oe & ~pull;

  initial forever @(posedge clk) begin
    cyc++;
    rst_d = rst;
  end

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push(input int idx, input int period);
    exp_t e;
    e.data   = {8'h34, ROM_TB[idx]};
    e.period = period;
    exp_q.push_back(e);
  endtask

  // Monitor: decode bus, act as slave, check protocol, pop scoreboard at STOP.
  initial begin
    logic       prev_scl, prev_line, line, in_frame, have_start, nk;
    int         bitcnt, byte_idx, last_start, cur_period;
    logic [7:0] fb [3];
    logic [7:0] sh;
    exp_t       e;
    prev_scl = 1'b1; prev_line = 1'b1; in_frame = 1'b0; have_start = 1'b0;
    bitcnt = 0; byte_idx = 0; last_start = 0; cur_period = 0; sh = '0;
    fb[0] = '0; fb[1] = '0; fb[2] = '0;
    forever begin
      @(negedge clk);
      if (rst_d) begin
        pull = 1'b0; in_frame = 1'b0; have_start = 1'b0; bitcnt = 0; byte_idx = 0;
        prev_scl = scl; prev_line = ~sda_oe;
      end else begin
        if (scl != prev_scl) scl_toggles++;
        if (prev_scl && !scl) begin
          pull = 1'b0;
          if (in_frame && bitcnt == 8) begin
            nk = (nack_mode == 1 && byte_idx == 1 && fb[1] == 8'h04 && !nacked_once) ||
                 (nack_mode == 2 && byte_idx == 1 && fb[1] == 8'h08);
            if (nk && nack_mode == 1) nacked_once = 1;
            pull = !nk;
          end
        end
        line = ~sda_oe & ~pull;
        if (line != prev_line) begin
          if (prev_scl && scl) begin
            if (!line) begin
              in_frame = 1'b1; bitcnt = 0; byte_idx = 0; starts++;
              cur_period = have_start ? (cyc - last_start) : 0;
              last_start = cyc; have_start = 1'b1;
            end else if (in_frame) begin
              in_frame = 1'b0; frames++; stop_cyc = cyc;
              $display("frame %0d: %02h %02h %02h period %0d", frames, fb[0], fb[1], fb[2], cur_period);
              chk("frame_len", byte_idx, 3);
              if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_frame: got %02h%02h%02h expected none", fb[0], fb[1], fb[2]);
              end else begin
                e = exp_q.pop_front();
                chk("frame_data", 32'({fb[0], fb[1], fb[2]}), 32'(e.data));
                if (e.period != 0) chk("frame_period", cur_period, e.period);
              end
            end
          end else begin
            checks++;
            if (scl) begin
              errors++;
              $display("FAIL sda_change_scl_high: got scl=%0b expected scl=0 (cycle %0d)", scl, cyc);
            end
          end
        end
        if (!prev_scl && scl && in_frame) begin
          if (bitcnt < 8) begin
            sh = {sh[6:0], line};
            bitcnt++;
            if (bitcnt == 8 && byte_idx < 3) fb[byte_idx] = sh;
          end else begin
            bitcnt = 0;
            byte_idx++;
          end
        end
        prev_scl = scl; prev_line = line;
      end
    end
  end

  task automatic reset_and_check();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_scl", 32'(scl), 1);
    chk("rst_sda_oe", 32'(sda_oe), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_idx", 32'(cmd_idx), 0);
  endtask

  task automatic wait_end(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done || err) break;
      @(negedge clk);
    end
  endtask

  task automatic wait_idx(input logic [3:0] idx, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (cmd_idx == idx && busy) break;
      @(negedge clk);
    end
    chk("wait_idx", 32'(cmd_idx), 32'(idx));
  endtask

  task automatic push_run();
    for (int i = 0; i < 11; i++) push(i, (i == 0) ? 0 : 63);
  endtask

  initial begin
    int f0, t0, s0;
    @(negedge clk);

    // 1: clean auto-started run
    reset_and_check();
    push_run();
    f0 = frames;
    rst = 1'b0;
    wait_end(2000);
    chk("t1_done", 32'(done), 1);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_err", 32'(err), 0);
    chk("t1_idx", 32'(cmd_idx), 10);
    chk("t1_done_after_stop", cyc - stop_cyc, 1);
    chk("t1_frames", frames - f0, 11);

    // 2: one NACK on idx 3, resent once
    reset_and_check();
    nack_mode = 1; nacked_once = 0;
    for (int i = 0; i < 11; i++) begin
      push(i, (i == 0) ? 0 : 63);
      if (i == 3) push(3, 63);
    end
    f0 = frames;
    rst = 1'b0;
    wait_end(2000);
    chk("t2_done", 32'(done), 1);
    chk("t2_err", 32'(err), 0);
    chk("t2_frames", frames - f0, 12);

    // 3: idx 5 always NACKed -> error after 4 attempts
    reset_and_check();
    nack_mode = 2;
    for (int i = 0; i < 5; i++) push(i, (i == 0) ? 0 : 63);
    for (int i = 0; i < 4; i++) push(5, 63);
    f0 = frames;
    rst = 1'b0;
    wait_end(2000);
    chk("t3_err", 32'(err), 1);
    chk("t3_done", 32'(done), 0);
    chk("t3_busy", 32'(busy), 0);
    chk("t3_idx", 32'(cmd_idx), 5);
    chk("t3_frames", frames - f0, 9);
    t0 = scl_toggles;
    repeat (100) @(negedge clk);
    chk("t3_scl_quiet", scl_toggles - t0, 0);
    chk("t3_scl_level", 32'(scl), 1);

    // 4: i_start mid-frame ignored, then restart from DONE
    reset_and_check();
    nack_mode = 0;
    push_run();
    f0 = frames;
    rst = 1'b0;
    wait_idx(4'd2, 1000);
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_end(2000);
    chk("t4_done", 32'(done), 1);
    chk("t4_frames", frames - f0, 11);
    repeat (5) @(negedge clk);
    push_run();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t4_restart_done", 32'(done), 0);
    chk("t4_restart_busy", 32'(busy), 1);
    chk("t4_restart_idx", 32'(cmd_idx), 0);
    wait_end(2000);
    chk("t4_rerun_done", 32'(done), 1);

    // 5: reset during bit slot 10 of idx 4
    reset_and_check();
    for (int i = 0; i < 4; i++) push(i, (i == 0) ? 0 : 63);
    rst = 1'b0;
    wait_idx(4'd4, 1000);
    s0 = starts;
    for (int i = 0; i < 100 && starts == s0; i++) @(negedge clk);
    chk("t5_start_seen", starts - s0, 1);
    repeat (21) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_scl", 32'(scl), 1);
    chk("t5_rst_sda_oe", 32'(sda_oe), 0);
    chk("t5_rst_flags", 32'({busy, done, err}), 0);
    chk("t5_queue_drained", exp_q.size(), 0);
    push_run();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_auto_busy", 32'(busy), 1);
    chk("t5_auto_idx", 32'(cmd_idx), 0);
    wait_end(2000);
    chk("t5_done", 32'(done), 1);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
